// File: rtl/cosim_constants_pkg.sv
// Width constants shared by the co-simulation capture logic.
package cosim_constants_pkg;

    localparam int unsigned XREG_W   = 64;
    localparam int unsigned FREG_W   = 64;
    localparam int unsigned SEQ_W    = 64;
    localparam int unsigned REG_ID_W = 12;

endpackage

// File: rtl/cosim_pkg.sv
// Types exchanged between the core retire port and the co-simulation checker.
package cosim_pkg;

    import cosim_constants_pkg::*;

    typedef logic [XREG_W-1:0] reg_t;
    typedef logic [FREG_W-1:0] freg_t;

    typedef enum logic [1:0] {
        RegTypeX   = 2'd0,
        RegTypeF   = 2'd1,
        RegTypeCsr = 2'd2
    } reg_type_e;

    typedef struct packed {
        reg_type_e             kind;
        logic [REG_ID_W-1:0]   id;
    } reg_key_t;

    typedef struct packed {
        reg_key_t key;
        freg_t    value;
    } commit_log_reg_item_t;

    // seq is always SEQ_W wide; narrower counters are zero-extended into it.
    typedef struct packed {
        logic [SEQ_W-1:0] seq;
        reg_t             pc;
        logic             rd_we;
        reg_key_t         key;
        freg_t            value;
    } commit_entry_t;

endpackage

// File: rtl/cosim_sync_fifo.sv
// Generic synchronous FIFO with a registered head and clear.
// Output data is zero whenever the FIFO is empty.
module cosim_sync_fifo #(
    parameter type         T     = logic [7:0],
    parameter int unsigned Depth = 16,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clr_i,
    input  logic            wr_valid_i,
    output logic            wr_ready_o,
    input  T                wr_data_i,
    output logic            rd_valid_o,
    input  logic            rd_ready_i,
    output T                rd_data_o,
    output logic [CntW-1:0] level_o
);

    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    T                mem_q [Depth];

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full  = (count_q == CntW'(Depth));
    assign empty = (count_q == '0);
    // Clear overrides any transfer in the same cycle.
    assign push  = wr_valid_i && !full && !clr_i;
    assign pop   = rd_ready_i && !empty && !clr_i;

    assign wr_ready_o = !full;
    assign rd_valid_o = !empty;
    assign level_o    = count_q;

    // Pointer and occupancy bookkeeping; Depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    // Storage write; contents need no reset because the head is masked when empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Head read from registered storage, forced to zero when nothing is buffered.
    always_comb begin
        rd_data_o = '0;
        if (!empty) begin
            rd_data_o = mem_q[rd_ptr_q];
        end
    end

endmodule

// File: rtl/cosim_commit_fifo.sv
// Capture stage between the core retire port and the co-simulation checker.
// Tags each retirement with a sequence number, buffers it, and flags drops.
module cosim_commit_fifo
    import cosim_pkg::*;
#(
    parameter int unsigned Depth = 16,
    parameter int unsigned SeqW  = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     commit_valid_i,
    output logic                     commit_ready_o,
    input  reg_t                     commit_pc_i,
    input  logic                     commit_rd_we_i,
    input  reg_key_t                 commit_rd_key_i,
    input  freg_t                    commit_rd_value_i,
    input  logic                     flush_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output commit_entry_t            out_entry_o,
    output logic [$clog2(Depth):0]   level_o,
    output logic                     overflow_o
);

    localparam int unsigned EntrySeqW = $bits(out_entry_o.seq);

    logic [SeqW-1:0] seq_q;
    logic            overflow_q;
    commit_entry_t   wr_entry;

    // Sequence advances on every retirement so the checker can see gaps for lost ones.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            seq_q <= '0;
        end else if (commit_valid_i) begin
            seq_q <= seq_q + SeqW'(1);
        end
    end

    // Sticky drop flag; a retirement arriving during flush is discarded, not dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overflow_q <= 1'b0;
        end else if (commit_valid_i && !commit_ready_o && !flush_i) begin
            overflow_q <= 1'b1;
        end
    end

    // Build the stored entry; key and value are meaningless without a register write.
    always_comb begin
        wr_entry       = '0;
        wr_entry.seq   = EntrySeqW'(seq_q);
        wr_entry.pc    = commit_pc_i;
        wr_entry.rd_we = commit_rd_we_i;
        if (commit_rd_we_i) begin
            wr_entry.key   = commit_rd_key_i;
            wr_entry.value = commit_rd_value_i;
        end
    end

    assign overflow_o = overflow_q;

    cosim_sync_fifo #(
        .T     (commit_entry_t),
        .Depth (Depth)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (flush_i),
        .wr_valid_i (commit_valid_i),
        .wr_ready_o (commit_ready_o),
        .wr_data_i  (wr_entry),
        .rd_valid_o (out_valid_o),
        .rd_ready_i (out_ready_i),
        .rd_data_o  (out_entry_o),
        .level_o    (level_o)
    );

endmodule

// File: tb/tb_cosim_commit_fifo.sv
// Directed scoreboard bench for cosim_commit_fifo.
module tb_cosim_commit_fifo;

    import cosim_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: Depth 16, SeqW 64.
    logic          rst, cv, we, flush, ordy;
    reg_t          pc;
    reg_key_t      key;
    freg_t         val;
    logic          crdy, ovalid, ovf;
    commit_entry_t oentry;
    logic [4:0]    level;

    // Wrap instance: Depth 4, SeqW 4.
    logic          rst_b, cv_b, we_b, flush_b, ordy_b;
    reg_t          pc_b;
    reg_key_t      key_b;
    freg_t         val_b;
    logic          crdy_b, ovalid_b, ovf_b;
    commit_entry_t oentry_b;
    logic [2:0]    level_b;

    cosim_commit_fifo #(.Depth(16), .SeqW(64)) u_dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .commit_valid_i    (cv),
        .commit_ready_o    (crdy),
        .commit_pc_i       (pc),
        .commit_rd_we_i    (we),
        .commit_rd_key_i   (key),
        .commit_rd_value_i (val),
        .flush_i           (flush),
        .out_valid_o       (ovalid),
        .out_ready_i       (ordy),
        .out_entry_o       (oentry),
        .level_o           (level),
        .overflow_o        (ovf)
    );

    cosim_commit_fifo #(.Depth(4), .SeqW(4)) u_dut_b (
        .clk_i             (clk),
        .rst_i             (rst_b),
        .commit_valid_i    (cv_b),
        .commit_ready_o    (crdy_b),
        .commit_pc_i       (pc_b),
        .commit_rd_we_i    (we_b),
        .commit_rd_key_i   (key_b),
        .commit_rd_value_i (val_b),
        .flush_i           (flush_b),
        .out_valid_o       (ovalid_b),
        .out_ready_i       (ordy_b),
        .out_entry_o       (oentry_b),
        .level_o           (level_b),
        .overflow_o        (ovf_b)
    );

    int total = 0;
    int bad   = 0;

    commit_entry_t exp_a [$];
    commit_entry_t exp_b [$];
    commit_entry_t mon_a;
    commit_entry_t mon_b;

    reg_key_t kx5  = '{kind: RegTypeX, id: 12'd5};
    reg_key_t junk = '{kind: RegTypeF, id: 12'h3FF};

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic commit_entry_t mk(input logic [63:0] s, input reg_t p, input logic w,
                                         input reg_key_t k, input freg_t v);
        commit_entry_t e;
        e.seq   = s;
        e.pc    = p;
        e.rd_we = w;
        e.key   = w ? k : '0;
        e.value = w ? v : '0;
        return e;
    endfunction

    // Monitors: pop and compare whenever the DUT hands an entry to the checker.
    always @(negedge clk) begin
        if (!rst && ovalid && ordy && !flush) begin
            if (exp_a.size() == 0) begin
                check("unexpected_pop_a", 1, 0);
            end else begin
                mon_a = exp_a.pop_front();
                check("entry_a", oentry, mon_a);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_b && ovalid_b && ordy_b && !flush_b) begin
            if (exp_b.size() == 0) begin
                check("unexpected_pop_b", 1, 0);
            end else begin
                mon_b = exp_b.pop_front();
                check("entry_b", oentry_b, mon_b);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input reg_t p, input logic w, input reg_key_t k, input freg_t v,
                          input logic accepted, input logic [63:0] s);
        cv  = 1'b1;
        pc  = p;
        we  = w;
        key = k;
        val = v;
        if (accepted) exp_a.push_back(mk(s, p, w, k, v));
        step();
        cv = 1'b0;
    endtask

    task automatic push_b(input reg_t p, input logic [63:0] s);
        cv_b = 1'b1;
        pc_b = p;
        we_b = 1'b1;
        key_b = kx5;
        val_b = 64'hAB;
        exp_b.push_back(mk(s, p, 1'b1, kx5, 64'hAB));
        step();
        cv_b = 1'b0;
    endtask

    task automatic reset_a();
        rst = 1'b1;
        cv = 1'b0;
        flush = 1'b0;
        ordy = 1'b0;
        step();
        rst = 1'b0;
        exp_a.delete();
    endtask

    task automatic drain_a();
        ordy = 1'b1;
        for (int i = 0; i < 40 && level != 0; i++) step();
        check("drain_level_a", level, 0);
        ordy = 1'b0;
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_ready"}, crdy, 1);
        check({tag, "_valid"}, ovalid, 0);
        check({tag, "_entry"}, oentry, 0);
        check({tag, "_level"}, level, 0);
        check({tag, "_ovf"}, ovf, 0);
    endtask

    initial begin
        rst = 1'b1; cv = 1'b0; we = 1'b0; flush = 1'b0; ordy = 1'b0;
        pc = '0; key = '0; val = '0;
        rst_b = 1'b1; cv_b = 1'b0; we_b = 1'b0; flush_b = 1'b0; ordy_b = 1'b0;
        pc_b = '0; key_b = '0; val_b = '0;
        step();
        step();
        rst = 1'b0;
        rst_b = 1'b0;
        check_reset_a("reset");

        // Three retirements, middle one writes x5.
        push_a(64'h8000_0000, 1'b0, junk, 64'h1234, 1'b1, 0);
        check("push_empty_valid", ovalid, 1);
        check("push_empty_head", oentry, mk(0, 64'h8000_0000, 1'b0, '0, '0));
        push_a(64'h8000_0004, 1'b1, kx5, 64'hDEAD, 1'b1, 1);
        push_a(64'h8000_0008, 1'b0, junk, 64'h5555, 1'b1, 2);
        check("level_three", level, 3);
        drain_a();
        check("valid_after_drain", ovalid, 0);

        // Fill, overflow, drain.
        reset_a();
        for (int i = 0; i < 16; i++) push_a(64'h1000 + 64'(4 * i), 1'b0, junk, '0, 1'b1, 64'(i));
        check("full_level", level, 16);
        check("full_ready", crdy, 0);
        push_a(64'h2000, 1'b1, kx5, 64'h1, 1'b0, 16);
        check("overflow_set", ovf, 1);
        check("full_level_after_drop", level, 16);
        ordy = 1'b1;
        check("ready_during_full_pop", crdy, 0);
        step();
        check("ready_after_full_pop", crdy, 1);
        check("level_after_full_pop", level, 15);
        drain_a();
        check("overflow_sticky", ovf, 1);
        push_a(64'h3000, 1'b1, kx5, 64'h77, 1'b1, 17);
        drain_a();

        // Steady state at level 5 with simultaneous push and pop.
        for (int i = 0; i < 5; i++) push_a(64'h4000 + 64'(4 * i), 1'b0, junk, '0, 1'b1, 64'(18 + i));
        check("level_five", level, 5);
        ordy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push_a(64'h5000 + 64'(4 * i), 1'b1, kx5, 64'(i), 1'b1, 64'(23 + i));
            check("level_steady", level, 5);
        end
        drain_a();

        // Flush at level 7 with a concurrent push and pop request.
        reset_a();
        for (int i = 0; i < 7; i++) push_a(64'h6000 + 64'(4 * i), 1'b0, junk, '0, 1'b1, 64'(i));
        check("level_seven", level, 7);
        flush = 1'b1;
        ordy = 1'b1;
        push_a(64'h6100, 1'b0, junk, '0, 1'b0, 7);
        flush = 1'b0;
        ordy = 1'b0;
        exp_a.delete();
        check("flush_level", level, 0);
        check("flush_valid", ovalid, 0);
        check("flush_ovf", ovf, 0);
        check("flush_entry", oentry, 0);
        push_a(64'h7000, 1'b0, junk, '0, 1'b1, 8);
        drain_a();

        // Reset at level 4 with overflow set.
        for (int i = 0; i < 16; i++) push_a(64'h9000 + 64'(4 * i), 1'b0, junk, '0, 1'b1, 64'(9 + i));
        push_a(64'h9100, 1'b0, junk, '0, 1'b0, 25);
        check("overflow_again", ovf, 1);
        ordy = 1'b1;
        repeat (12) step();
        ordy = 1'b0;
        check("level_four", level, 4);
        check("overflow_before_reset", ovf, 1);
        reset_a();
        check_reset_a("midrun_reset");
        push_a(64'h8000, 1'b0, junk, '0, 1'b1, 0);
        drain_a();

        // Narrow sequence counter wraps modulo 16.
        flush_b = 1'b1;
        cv_b = 1'b1;
        repeat (14) step();
        cv_b = 1'b0;
        flush_b = 1'b0;
        check("wrap_level_pre", level_b, 0);
        push_b(64'hA000, 14);
        push_b(64'hA004, 15);
        push_b(64'hA008, 0);
        check("wrap_level", level_b, 3);
        ordy_b = 1'b1;
        for (int i = 0; i < 20 && level_b != 0; i++) step();
        check("wrap_drain", level_b, 0);
        check("wrap_ovf", ovf_b, 0);
        ordy_b = 1'b0;

        check("scoreboard_a_empty", exp_a.size(), 0);
        check("scoreboard_b_empty", exp_b.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cosim_commit_fifo.md
# cosim_commit_fifo

Synthesizable capture stage between the DUT core's retire port and the co-simulation checker. It records one entry per retired instruction: PC, optional register write key/value and a sequence number. Entries are buffered in a FIFO and presented to the checker over a valid/ready handshake. For each popped entry the checker steps spike once and compares the entry against spike's PC and register-write log.

## Interface
Parameters:
- Depth, 16, FIFO entries; power of two, ≥2 (matches CommitLogEntries)
- SeqW, 64, sequence counter width

Ports:
- Clocking and reset (already decided): one clock `clk_i`; reset `rst_i`, synchronous, active-high.
- `commit_valid_i`  in  1  core retired an instruction this cycle
- `commit_ready_o`  out  1  FIFO can accept (not full)
- `commit_pc_i`  in  XREG_W  reg_t, PC of the retired instruction
- `commit_rd_we_i`  in  1  instruction wrote a register
- `commit_rd_key_i`  in  reg_key_t  written register (type + id)
- `commit_rd_value_i`  in  FREG_W  freg_t, written value (zero-extended XREG)
- `flush_i`  in  1  discard all buffered entries
- `out_valid_o`  out  1  head entry valid
- `out_ready_i`  in  1  checker consumes head
- `out_entry_o`  out  commit_entry_t  head entry
- `level_o`  out  $clog2(Depth)+1  current occupancy
- `overflow_o`  out  1  sticky: a retirement was dropped

## Operation
- Push condition: `commit_valid_i && commit_ready_o && !flush_i` writes {seq_q, pc, rd_we, key, value} at the write pointer.
- When `commit_rd_we_i`=0, the stored key and value are forced to 0.
- Pop condition: `out_valid_o && out_ready_i && !flush_i` advances the read pointer.
- Sequence counter:
  - `seq_q` increments on every `commit_valid_i`, whether the entry is accepted, dropped or flushed.
  - The checker therefore sees gaps in seq for lost instructions.
  - `seq_q` wraps modulo 2^SeqW.
- Overflow: `commit_valid_i && !commit_ready_o` drops the entry and sets `overflow_o`. Only reset clears it; flush does not.
- Flush:
  - Next cycle: pointers and count are 0.
  - `seq_q` and `overflow_o` are unaffected.
  - A push or pop in the same cycle is ignored, and a push in that cycle does not set overflow.
- Pointers are $clog2(Depth) bits and wrap naturally.
- Count is updated as +1 for push only, −1 for pop only, unchanged for both or neither.
- Two states are derived from count: EMPTY (count=0) and FULL (count=Depth). There is no other FSM.

## Timing
- Reset values:
  - `commit_ready_o`=1
  - `out_valid_o`=0
  - `out_entry_o`=0
  - `level_o`=0
  - `overflow_o`=0
  - `seq_q`=0
- All outputs are registered or decoded from registered state only; there is no combinational input-to-output path.
- Latency: an entry pushed in cycle t is visible on `out_*` at t+1 at the earliest. There is no fall-through.
- `commit_ready_o` = !FULL from the registered count. A simultaneous pop while FULL does not raise ready in the same cycle.
- Push and pop in the same cycle at 0<count<Depth: count is unchanged, and the head advances to the next entry at t+1.
- Push into EMPTY: `out_valid_o` rises at t+1, and `out_entry_o` is the pushed entry.
- `out_entry_o` is stable while `out_valid_o && !out_ready_i`.
- Reset asserted mid-operation clears everything at the next edge; entries in flight are lost without setting overflow.

## Structure
- `commit_entry_t` (packed struct: seq, pc, rd_we, key, value) is added to `cosim_pkg` next to `commit_log_reg_item_t`.
- reg_t, freg_t and reg_key_t come from `cosim_pkg`; widths come from `cosim_constants_pkg`.
- Sub-module `cosim_sync_fifo`:
  - generic, parameterized by type and Depth;
  - holds the pointers, count and storage with registered head.
- `cosim_commit_fifo` wraps `cosim_sync_fifo` and adds the seq counter, the write-data masking, the overflow flag and flush gating.

## Test plan
- Reset, then push 3 retirements: PC 0x80000000/04/08, the second with XREG id 5 = 0xDEAD.
  - Expected: pops are in order with seq 0,1,2.
  - Entries 0 and 2 have rd_we=0 and key/value=0.
- Push 16 with `out_ready_i`=0, then a 17th.
  - Expected: `level_o`=16 and `commit_ready_o`=0.
  - The 17th is dropped and `overflow_o`=1.
  - The next accepted entry after draining has seq 17.
- At level 5, push and pop in the same cycle for 10 cycles.
  - Expected: `level_o` stays 5, and popped seqs are contiguous.
- Flush at level 7 with a concurrent push.
  - Expected: level 0 next cycle, `out_valid_o`=0, overflow stays 0.
  - The next push carries seq 8.
- Assert `rst_i` at level 4 with overflow set.
  - Expected: all outputs at reset values next cycle; the next push has seq 0.
- Preload `seq_q` near 2^SeqW−1 (bench forces SeqW=4) and push 3.
  - Expected: seq 14, 15, 0.
